// File: rtl/serial_pkg.sv
// Shared definitions for the host serial command link: command codes,
// response-transmitter FSM encoding and the frame-length helper.
package serial_pkg;

  localparam logic [7:0] CMD_SET_ADDR = 8'h01;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  // Header byte + payload bytes + optional checksum byte.
  function automatic int unsigned nbytes(input int unsigned data_bytes,
                                         input int unsigned checksum_en);
    return 32'd1 + data_bytes + checksum_en;
  endfunction

endpackage

// File: rtl/serial_resp_tx.sv
// Response transmitter: serialises {cmd, payload[, xor checksum]} MSB first
// toward the UART byte port, one strobe per byte, respecting tx_busy.
module serial_resp_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned CHECKSUM_EN = 1,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [7:0]  resp_cmd,
  input  logic [31:0] resp_data,
  input  logic        tx_busy,
  output logic        tx_strb,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0]  NBYTES   = 3'(nbytes(DATA_BYTES, CHECKSUM_EN));
  localparam int unsigned PAD_BITS = 32 - 8 * DATA_BYTES;
  localparam logic [7:0]  GAP_LOAD = (GAP_CYCLES > 32'd0) ? 8'(GAP_CYCLES - 32'd1) : 8'd0;

  tx_state_e   state_q, state_d;
  logic [39:0] sreg_q, sreg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  csum_q, csum_d;
  logic        strb_q, strb_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept_s;
  logic        send_s;
  logic [7:0]  cur_byte_s;
  logic [31:0] data_al_s;

  assign accept_s   = resp_valid && ready_q && (state_q == ST_IDLE);
  assign send_s     = (state_q == ST_SEND) && !tx_busy;
  // Selected payload bytes are left-aligned so the shift reg always emits from its top byte.
  assign data_al_s  = resp_data << PAD_BITS;
  assign cur_byte_s = ((CHECKSUM_EN != 32'd0) && (cnt_q == 3'd1)) ? csum_q : sreg_q[39:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_SEND;
        else          state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (!tx_busy) state_d = ST_HOLD;
        else          state_d = ST_SEND;
      end
      ST_HOLD: begin
        if (GAP_CYCLES != 32'd0) state_d = ST_GAP;
        else if (cnt_q == 3'd0)  state_d = ST_IDLE;
        else                     state_d = ST_SEND;
      end
      ST_GAP: begin
        if (gap_q != 8'd0)      state_d = ST_GAP;
        else if (cnt_q == 3'd0) state_d = ST_IDLE;
        else                    state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    csum_d = csum_q;
    gap_d  = gap_q;
    strb_d = 1'b0;
    data_d = data_q;
    if (accept_s) begin
      sreg_d = {resp_cmd, data_al_s};
      cnt_d  = NBYTES;
      csum_d = 8'h00;
    end else if (send_s) begin
      strb_d = 1'b1;
      data_d = cur_byte_s;
      csum_d = csum_q ^ cur_byte_s;
      cnt_d  = cnt_q - 3'd1;
      sreg_d = {sreg_q[31:0], 8'h00};
    end else begin
      strb_d = 1'b0;
    end
    if (state_q == ST_HOLD) begin
      gap_d = GAP_LOAD;
    end else if ((state_q == ST_GAP) && (gap_q != 8'd0)) begin
      gap_d = gap_q - 8'd1;
    end else begin
      gap_d = gap_q;
    end
    // Status flags follow the next state so they line up with the state register.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q  <= 40'h0;
      cnt_q   <= 3'd0;
      gap_q   <= 8'd0;
      csum_q  <= 8'h00;
      strb_q  <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      csum_q  <= csum_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign resp_ready = ready_q;
  assign tx_strb    = strb_q;
  assign tx_data    = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_resp_tx.sv
// Bench for serial_resp_tx: three configurations (default, 1-byte/no checksum,
// 3-cycle gap) checked against a byte-list reference model and a UART busy model.
module tb_serial_resp_tx;
  import serial_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  v = 3'b000;
  logic [7:0]  cmd_i = 8'h00;
  logic [31:0] data_i = 32'h0;
  logic [2:0]  rdy, strb, bsy, dn;
  logic [7:0]  txd [3];
  logic        busy0;
  logic [7:0]  bcnt = 8'd0;
  logic        busy_at_edge = 1'b0;
  int          blen = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct { int k; logic [7:0] b; int c; } ev_t;
  ev_t ev_q[$];

  typedef struct { logic [7:0] cmd; logic [31:0] data; logic [7:0] ck; int bl; } vec_t;
  vec_t tbl [5];

  serial_resp_tx #(.DATA_BYTES(4), .CHECKSUM_EN(1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .resp_valid(v[0]), .resp_ready(rdy[0]),
    .resp_cmd(cmd_i), .resp_data(data_i), .tx_busy(busy0), .tx_strb(strb[0]),
    .tx_data(txd[0]), .busy(bsy[0]), .done(dn[0]));

  serial_resp_tx #(.DATA_BYTES(1), .CHECKSUM_EN(0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .resp_valid(v[1]), .resp_ready(rdy[1]),
    .resp_cmd(cmd_i), .resp_data(data_i), .tx_busy(1'b0), .tx_strb(strb[1]),
    .tx_data(txd[1]), .busy(bsy[1]), .done(dn[1]));

  serial_resp_tx #(.DATA_BYTES(4), .CHECKSUM_EN(1), .GAP_CYCLES(3)) u2 (
    .clk(clk), .reset(reset), .resp_valid(v[2]), .resp_ready(rdy[2]),
    .resp_cmd(cmd_i), .resp_data(data_i), .tx_busy(1'b0), .tx_strb(strb[2]),
    .tx_data(txd[2]), .busy(bsy[2]), .done(dn[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model for u0: busy rises the cycle after a strobe and stays up blen cycles.
  always @(posedge clk) begin
    if (strb[0]) bcnt <= 8'(blen);
    else if (bcnt != 8'd0) bcnt <= bcnt - 8'd1;
    busy_at_edge <= busy0;
  end
  assign busy0 = (bcnt != 8'd0);

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (strb[k]) ev_q.push_back('{k, txd[k], cyc});
    if (strb[0]) begin
      total++;
      if (busy_at_edge) begin
        bad++;
        $display("FAIL strobe_while_busy: strobe at cycle %0d with tx_busy=1", cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int count_k(input int k);
    int n;
    n = 0;
    foreach (ev_q[i]) if (ev_q[i].k == k) n++;
    return n;
  endfunction

  task automatic send(input int k, input logic [7:0] cmd, input logic [31:0] d, output int acc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((!rdy[k] || busy0) && n < 200);
    chk("ready_wait", {31'd0, rdy[k]}, 32'd1);
    cmd_i = cmd; data_i = d; v[k] = 1'b1;
    @(posedge clk); #1;
    acc = cyc; v[k] = 1'b0;
    cmd_i = 8'($urandom); data_i = $urandom;
    @(negedge clk);
    chk("ready_low", {31'd0, rdy[k]}, 32'd0);
    chk("busy_high", {31'd0, bsy[k]}, 32'd1);
  endtask

  task automatic wait_done(input int k, output int dcyc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!dn[k] && n < 600);
    chk("done_seen", {31'd0, dn[k]}, 32'd1);
    dcyc = cyc;
    @(negedge clk);
    chk("done_pulse", {31'd0, dn[k]}, 32'd0);
    chk("ready_idle", {31'd0, rdy[k]}, 32'd1);
  endtask

  // Reference: expected byte list, strobe spacing and done timing from the frame rules.
  task automatic check_frame(input int k, input int skip, input bit exact, input logic [7:0] cmd,
                             input logic [31:0] d, input int acc, input int bl, input int dcyc);
    int db, cs, gap, sp, idx, found, prev;
    logic [7:0] e[$];
    logic [7:0] x;
    db = (k == 1) ? 1 : 4;
    cs = (k == 1) ? 0 : 1;
    gap = (k == 2) ? 3 : 0;
    sp = 2 + gap + ((k == 0) ? bl : 0);
    e.push_back(cmd);
    for (int i = db - 1; i >= 0; i--) e.push_back(d[8*i +: 8]);
    if (cs != 0) begin
      x = 8'h00;
      foreach (e[j]) x = x ^ e[j];
      e.push_back(x);
    end
    idx = 0; found = 0; prev = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].k == k) begin
        if (idx >= skip && found < e.size()) begin
          chk($sformatf("byte%0d_k%0d", found, k), {24'd0, ev_q[i].b}, {24'd0, e[found]});
          if (found == 0) chk("first_latency", ev_q[i].c, acc + 1);
          else            chk("strobe_spacing", ev_q[i].c - prev, sp);
          prev = ev_q[i].c;
          found++;
        end
        idx++;
      end
    end
    chk("byte_count", exact ? (idx - skip) : found, e.size());
    chk("done_time", dcyc, prev + 1 + gap);
  endtask

  initial begin
    int acc, dcyc, acc_a, acc_b, d_a, d_b, n, s;
    logic [7:0] lastb, rc;
    logic [31:0] rd;
    int rk;

    tbl[0] = '{CMD_READ,     32'hAABBCCDD, 8'h03, 0};
    tbl[1] = '{CMD_SET_ADDR, 32'h000000FF, 8'hFE, 10};
    tbl[2] = '{CMD_START,    32'h12345678, 8'h0C, 3};
    tbl[3] = '{CMD_WRITE,    32'hFFFFFFFF, 8'h02, 0};
    tbl[4] = '{8'h00,        32'h00000000, 8'h00, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'd0, rdy[k]}, 32'd0);
      chk("rst_strb",  {31'd0, strb[k]}, 32'd0);
      chk("rst_data",  {24'd0, txd[k]}, 32'd0);
      chk("rst_busy",  {31'd0, bsy[k]}, 32'd0);
      chk("rst_done",  {31'd0, dn[k]}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {29'd0, rdy}, 32'd7);

    for (int i = 0; i < 5; i++) begin
      blen = tbl[i].bl;
      ev_q.delete();
      send(0, tbl[i].cmd, tbl[i].data, acc);
      wait_done(0, dcyc);
      check_frame(0, 0, 1'b1, tbl[i].cmd, tbl[i].data, acc, blen, dcyc);
      lastb = 8'h00;
      if (ev_q.size() > 0) lastb = ev_q[ev_q.size()-1].b;
      chk("checksum_byte", {24'd0, lastb}, {24'd0, tbl[i].ck});
    end
    blen = 0;

    ev_q.delete();
    send(1, CMD_SET_ADDR, 32'h000000FF, acc);
    wait_done(1, dcyc);
    check_frame(1, 0, 1'b1, CMD_SET_ADDR, 32'h000000FF, acc, 0, dcyc);

    ev_q.delete();
    send(2, CMD_READ, 32'hAABBCCDD, acc);
    wait_done(2, dcyc);
    check_frame(2, 0, 1'b1, CMD_READ, 32'hAABBCCDD, acc, 0, dcyc);

    // Back-to-back: valid held high across the done cycle with a new word.
    ev_q.delete();
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy[0] && n < 200);
    cmd_i = CMD_WRITE; data_i = 32'h01020304; v[0] = 1'b1;
    @(posedge clk); #1;
    acc_a = cyc; cmd_i = CMD_READ; data_i = 32'hA5A55A5A;
    n = 0;
    do begin @(negedge clk); n++; end while (!dn[0] && n < 200);
    chk("b2b_done_seen", {31'd0, dn[0]}, 32'd1);
    d_a = cyc;
    chk("b2b_ready_on_done", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    acc_b = cyc; v[0] = 1'b0; data_i = $urandom;
    @(negedge clk);
    chk("b2b_busy", {31'd0, bsy[0]}, 32'd1);
    wait_done(0, d_b);
    check_frame(0, 0, 1'b0, CMD_WRITE, 32'h01020304, acc_a, 0, d_a);
    check_frame(0, 6, 1'b1, CMD_READ, 32'hA5A55A5A, acc_b, 0, d_b);

    // Reset one cycle after the third strobe.
    ev_q.delete();
    send(0, CMD_WRITE, 32'h11223344, acc);
    n = 0; s = 0;
    do begin @(negedge clk); n++; if (strb[0]) s++; end while (s < 3 && n < 100);
    chk("third_strobe", s, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_strb",  {31'd0, strb[0]}, 32'd0);
    chk("mid_rst_data",  {24'd0, txd[0]}, 32'd0);
    chk("mid_rst_busy",  {31'd0, bsy[0]}, 32'd0);
    chk("mid_rst_done",  {31'd0, dn[0]}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("mid_rst_ready_after", {31'd0, rdy[0]}, 32'd1);
    repeat (8) @(negedge clk);
    chk("no_strobe_after_reset", count_k(0), 3);
    ev_q.delete();
    send(0, CMD_READ, 32'hCAFEF00D, acc);
    wait_done(0, dcyc);
    check_frame(0, 0, 1'b1, CMD_READ, 32'hCAFEF00D, acc, 0, dcyc);

    for (int it = 0; it < 24; it++) begin
      rk = $urandom_range(0, 2);
      blen = (rk == 0) ? $urandom_range(0, 4) : 0;
      rc = 8'($urandom);
      rd = $urandom;
      ev_q.delete();
      send(rk, rc, rd, acc);
      wait_done(rk, dcyc);
      check_frame(rk, 0, 1'b1, rc, rd, acc, blen, dcyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
